// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: accepts one EX-stage memory op, issues one data-bus request, returns the extended load result.
// Latency: 1 cycle accept-to-result for no-op/misaligned ops, 3 cycles minimum for bus accesses.
// Backpressure: in_ready only in IDLE; req_* held until req_ready; result held until out_ready.
module ysyx_22050243_lsu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_w,
  input  logic             mem_r,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  input  logic [7:0]       store_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] load_data,
  output logic             misalign,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_addr,
  output logic             req_wen,
  output logic [WIDTH-1:0] req_wdata,
  output logic [7:0]       req_wmask,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic             mem_w_q;
  logic             mem_r_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] store_data_q;
  logic [7:0]       store_mask_q;

  // Legality of the incoming op, judged before it is captured.
  logic in_access;
  logic in_illegal;
  logic in_misal;
  logic in_bad;
  assign in_access  = mem_w | mem_r;
  assign in_illegal = (funct3 == 3'b111);
  assign in_bad     = in_illegal | in_misal;

  // Natural alignment check keyed on the size bits funct3[1:0].
  always_comb begin
    in_misal = 1'b0;
    case (funct3[1:0])
      2'b01:   in_misal = addr[0];
      2'b10:   in_misal = (addr[1:0] != 2'b00);
      2'b11:   in_misal = (addr[2:0] != 3'b000);
      default: in_misal = 1'b0;
    endcase
  end

  // Byte-lane shift amount within the 8-byte bus word.
  logic [5:0]       shamt;
  logic [WIDTH-1:0] rdata_sh;
  logic [WIDTH-1:0] load_ext;
  assign shamt    = {addr_q[2:0], 3'b000};
  assign rdata_sh = resp_rdata >> shamt;

  // Sign/zero extension of the lane-aligned response word.
  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{(WIDTH-8){rdata_sh[7]}},   rdata_sh[7:0]};
      3'b001:  load_ext = {{(WIDTH-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_ext = {{(WIDTH-32){rdata_sh[31]}}, rdata_sh[31:0]};
      3'b011:  load_ext = rdata_sh;
      3'b100:  load_ext = {{(WIDTH-8){1'b0}},  rdata_sh[7:0]};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, rdata_sh[15:0]};
      3'b110:  load_ext = {{(WIDTH-32){1'b0}}, rdata_sh[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Request payload is derived from the captured op, so it is stable for the whole REQ phase.
  // mem_w wins when both mem_w and mem_r are set.
  assign req_addr  = {addr_q[WIDTH-1:3], 3'b000};
  assign req_wen   = mem_w_q;
  assign req_wdata = mem_w_q ? (store_data_q << shamt) : '0;
  assign req_wmask = mem_w_q ? (store_mask_q << addr_q[2:0]) : 8'h00;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      req_valid    <= 1'b0;
      out_valid    <= 1'b0;
      misalign     <= 1'b0;
      load_data    <= '0;
      mem_w_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      store_mask_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mem_w_q      <= mem_w;
            mem_r_q      <= mem_r;
            funct3_q     <= funct3;
            addr_q       <= addr;
            store_data_q <= store_data;
            store_mask_q <= store_mask;
            in_ready     <= 1'b0;
            load_data    <= '0;
            if (in_access && !in_bad) begin
              state     <= REQ;
              req_valid <= 1'b1;
              misalign  <= 1'b0;
            end else begin
              // No-ops and bad accesses skip the bus entirely.
              state     <= DONE;
              out_valid <= 1'b1;
              misalign  <= in_access & in_bad;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Stores also wait here for the write acknowledge.
          if (resp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            load_data <= (mem_r_q && !mem_w_q) ? load_ext : '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
